systolic_result_drain: RTL and testbench

//  Downstream stage of the systolic convolution array. Captures the full K x K product

---
 rtl/systolic_result_drain.sv | 198 +++++++++++++++++++
 tb/tb_systolic_result_drain.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_result_drain.sv
`default_nettype none
// ============================================================================
// Module      : systolic_result_drain
// Description : Captures the K x K product matrix of the systolic convolution
//               array on a p_valid pulse and drains it one element per
//               valid/ready handshake in raster order, tagged with row/col.
//               Optional feature macro: RESULT_MAX_EN (per-frame maximum
//               element tracking with max_* result ports).
// Revision    : 1.0 - initial release
// ============================================================================

module systolic_result_drain #(
    parameter  int N          = 3,
    parameter  int M          = 2,
    parameter  int data_width = 1,
    localparam int K          = N - M + 1,
    localparam int PW         = 2 * data_width + 1,
    localparam int CW         = (K > 1) ? $clog2(K) : 1
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          p_valid,
    input  logic [PW-1:0] P [0:K-1][0:K-1],
    output logic          p_ready,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [PW-1:0] out_data,
    output logic [CW-1:0] out_row,
    output logic [CW-1:0] out_col,
    output logic          out_last,
    output logic          overrun
`ifdef RESULT_MAX_EN
    ,
    output logic          max_valid,
    output logic [PW-1:0] max_data,
    output logic [CW-1:0] max_row,
    output logic [CW-1:0] max_col
`endif
);

    // Last valid row/column index, sized to the index registers.
    localparam logic [CW-1:0] c_KM1 = CW'(K - 1);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_DRAIN = 1'b1
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;

    logic [PW-1:0] r_buf [0:K-1][0:K-1];
    logic [CW-1:0] r_row;
    logic [CW-1:0] r_col;
    logic          r_overrun;

    logic          w_capture;
    logic          w_advance;
    logic          w_at_last;

    // The element currently presented is the frame end when both indices top out.
    assign w_at_last = (r_row == c_KM1) && (r_col == c_KM1);

    // State register; async reset drops any frame in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and handshake decode; output stream is driven straight from registers.
    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        w_advance   = 1'b0;
        p_ready     = 1'b0;
        out_valid   = 1'b0;
        case (r_state)
            S_IDLE: begin
                p_ready = 1'b1;
                if (p_valid) begin
                    w_capture   = 1'b1;
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_advance = 1'b1;
                    if (w_at_last) begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Output element view; zero while idle so stale frames never leak out.
    always_comb begin
        out_data = '0;
        out_row  = r_row;
        out_col  = r_col;
        out_last = 1'b0;
        if (out_valid) begin
            out_data = r_buf[r_row][r_col];
            out_last = w_at_last;
        end
    end

    // Frame buffer and raster index: whole matrix copied on capture, indices step on handshake.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < K; i++) begin
                for (int j = 0; j < K; j++) begin
                    r_buf[i][j] <= '0;
                end
            end
            r_row <= '0;
            r_col <= '0;
        end else begin
            if (w_capture) begin
                r_buf <= P;
                r_row <= '0;
                r_col <= '0;
            end else if (w_advance) begin
                if (r_col == c_KM1) begin
                    r_col <= '0;
                    r_row <= w_at_last ? '0 : (r_row + 1'b1);
                end else begin
                    r_col <= r_col + 1'b1;
                end
            end
        end
    end

    // Sticky flag for frames offered while busy; those frames are dropped.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_overrun <= 1'b0;
        end else if (p_valid && !p_ready) begin
            r_overrun <= 1'b1;
        end
    end

    assign overrun = r_overrun;

`ifdef RESULT_MAX_EN
    logic          r_run_vld;
    logic [PW-1:0] r_run_data;
    logic [CW-1:0] r_run_row;
    logic [CW-1:0] r_run_col;
    logic          w_take;

    // Strictly-greater replacement keeps the earliest element on ties.
    assign w_take = !r_run_vld || (out_data > r_run_data);

    // Running maximum over handshaken elements, published at each frame end.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_run_vld  <= 1'b0;
            r_run_data <= '0;
            r_run_row  <= '0;
            r_run_col  <= '0;
            max_valid  <= 1'b0;
            max_data   <= '0;
            max_row    <= '0;
            max_col    <= '0;
        end else begin
            max_valid <= w_advance && w_at_last;
            if (w_capture) begin
                r_run_vld <= 1'b0;
            end else if (w_advance) begin
                if (w_take) begin
                    r_run_vld  <= 1'b1;
                    r_run_data <= out_data;
                    r_run_row  <= r_row;
                    r_run_col  <= r_col;
                end
                if (w_at_last) begin
                    max_data <= w_take ? out_data : r_run_data;
                    max_row  <= w_take ? r_row    : r_run_row;
                    max_col  <= w_take ? r_col    : r_run_col;
                end
            end
        end
    end
`else
    // Maximum tracking not built in this configuration.
`endif

endmodule

`default_nettype wire

// File: tb/tb_systolic_result_drain.sv
`default_nettype none
// ============================================================================
// Module      : tb_systolic_result_drain
// Description : Directed self-checking bench for systolic_result_drain
//               (N=3, M=2, data_width=1 -> K=2, PW=3, CW=1).
// Revision    : 1.0 - initial release
// ============================================================================

module tb_systolic_result_drain;

    localparam int K  = 2;
    localparam int PW = 3;
    localparam int CW = 1;

    logic          clk;
    logic          reset_n;
    logic          p_valid;
    logic [PW-1:0] P [0:K-1][0:K-1];
    logic          p_ready;
    logic          out_valid;
    logic          out_ready;
    logic [PW-1:0] out_data;
    logic [CW-1:0] out_row;
    logic [CW-1:0] out_col;
    logic          out_last;
    logic          overrun;
`ifdef RESULT_MAX_EN
    logic          max_valid;
    logic [PW-1:0] max_data;
    logic [CW-1:0] max_row;
    logic [CW-1:0] max_col;
`endif

    int passed = 0;
    int failed = 0;
    int total  = 0;

    systolic_result_drain #(
        .N          (3),
        .M          (2),
        .data_width (1)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .p_valid   (p_valid),
        .P         (P),
        .p_ready   (p_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_row   (out_row),
        .out_col   (out_col),
        .out_last  (out_last),
        .overrun   (overrun)
`ifdef RESULT_MAX_EN
        ,
        .max_valid (max_valid),
        .max_data  (max_data),
        .max_row   (max_row),
        .max_col   (max_col)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_p(input int a, input int b, input int c, input int d);
        P[0][0] = PW'(a);
        P[0][1] = PW'(b);
        P[1][0] = PW'(c);
        P[1][1] = PW'(d);
    endtask

    task automatic exp_elem(input string tag, input int d, input int r, input int c, input int l);
        chk({tag, "_valid"}, out_valid, 1);
        chk({tag, "_data"},  out_data,  d);
        chk({tag, "_row"},   out_row,   r);
        chk({tag, "_col"},   out_col,   c);
        chk({tag, "_last"},  out_last,  l);
        chk({tag, "_pready"}, p_ready,  0);
    endtask

    task automatic exp_idle(input string tag);
        chk({tag, "_valid"},  out_valid, 0);
        chk({tag, "_pready"}, p_ready,   1);
    endtask

    // Called just after the capture edge with out_ready=1; ends one cycle after the last handshake.
    task automatic drain4(input string tag, input int d0, input int d1, input int d2, input int d3);
        exp_elem({tag, "_e0"}, d0, 0, 0, 0);
        step();
        exp_elem({tag, "_e1"}, d1, 0, 1, 0);
        step();
        exp_elem({tag, "_e2"}, d2, 1, 0, 0);
        step();
        exp_elem({tag, "_e3"}, d3, 1, 1, 1);
        step();
        exp_idle({tag, "_end"});
    endtask

    initial begin
        reset_n   = 1'b0;
        p_valid   = 1'b0;
        out_ready = 1'b0;
        load_p(0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;

        // Reset state
        chk("rst_pready",  p_ready,   1);
        chk("rst_valid",   out_valid, 0);
        chk("rst_data",    out_data,  0);
        chk("rst_row",     out_row,   0);
        chk("rst_col",     out_col,   0);
        chk("rst_last",    out_last,  0);
        chk("rst_overrun", overrun,   0);
`ifdef RESULT_MAX_EN
        chk("rst_max_valid", max_valid, 0);
        chk("rst_max_data",  max_data,  0);
`endif

        // Test 1: plain drain at full rate
        load_p(4, 3, 3, 2);
        p_valid   = 1'b1;
        out_ready = 1'b1;
        step();
        p_valid = 1'b0;
        drain4("t1", 4, 3, 3, 2);
        chk("t1_overrun", overrun, 0);

        // Test 2: backpressure on the second element for three cycles
        p_valid = 1'b1;
        step();
        p_valid = 1'b0;
        exp_elem("t2_e0", 4, 0, 0, 0);
        step();
        exp_elem("t2_e1", 3, 0, 1, 0);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            exp_elem($sformatf("t2_hold%0d", i), 3, 0, 1, 0);
        end
        out_ready = 1'b1;
        step();
        exp_elem("t2_e2", 3, 1, 0, 0);
        step();
        exp_elem("t2_e3", 2, 1, 1, 1);
        step();
        exp_idle("t2_end");

        // Test 3: frame offered mid-drain is dropped and flagged
        p_valid = 1'b1;
        step();
        load_p(1, 1, 1, 1);
        exp_elem("t3_e0", 4, 0, 0, 0);
        step();
        p_valid = 1'b0;
        chk("t3_overrun_set", overrun, 1);
        exp_elem("t3_e1", 3, 0, 1, 0);
        step();
        exp_elem("t3_e2", 3, 1, 0, 0);
        step();
        exp_elem("t3_e3", 2, 1, 1, 1);
        step();
        exp_idle("t3_end");
        chk("t3_overrun_sticky", overrun, 1);

        // Test 6: p_valid held high, back-to-back frames with one idle cycle
        load_p(4, 3, 3, 2);
        p_valid = 1'b1;
        for (int f = 0; f < 2; f++) begin
            step();
            exp_elem($sformatf("t6_f%0d_e0", f), 4, 0, 0, 0);
            step();
            exp_elem($sformatf("t6_f%0d_e1", f), 3, 0, 1, 0);
            step();
            exp_elem($sformatf("t6_f%0d_e2", f), 3, 1, 0, 0);
            step();
            exp_elem($sformatf("t6_f%0d_e3", f), 2, 1, 1, 1);
            if (f == 1) p_valid = 1'b0;
            step();
            exp_idle($sformatf("t6_f%0d_gap", f));
        end
        step();
        exp_idle("t6_stay_idle");
        chk("t6_overrun_sticky", overrun, 1);

        // Test 4: async reset mid-drain, then a fresh frame
        p_valid = 1'b1;
        step();
        p_valid = 1'b0;
        exp_elem("t4_e0", 4, 0, 0, 0);
        step();
        exp_elem("t4_e1", 3, 0, 1, 0);
        step();
        exp_elem("t4_e2", 3, 1, 0, 0);
        #2;
        reset_n = 1'b0;
        #1;
        chk("t4_rst_valid",   out_valid, 0);
        chk("t4_rst_pready",  p_ready,   1);
        chk("t4_rst_data",    out_data,  0);
        chk("t4_rst_overrun", overrun,   0);
        #2;
        reset_n = 1'b1;
        load_p(2, 2, 2, 2);
        p_valid = 1'b1;
        step();
        p_valid = 1'b0;
        drain4("t4_new", 2, 2, 2, 2);
        chk("t4_overrun_clear", overrun, 0);

`ifdef RESULT_MAX_EN
        // Test 5: per-frame maximum with earliest-wins tie
        chk("t5_pre_valid", max_valid, 1);
        chk("t5_pre_data",  max_data,  2);
        step();
        chk("t5_pre_pulse_end", max_valid, 0);
        load_p(4, 3, 3, 2);
        p_valid = 1'b1;
        step();
        p_valid = 1'b0;
        chk("t5a_mid_valid", max_valid, 0);
        drain4("t5a", 4, 3, 3, 2);
        chk("t5a_max_valid", max_valid, 1);
        chk("t5a_max_data",  max_data,  4);
        chk("t5a_max_row",   max_row,   0);
        chk("t5a_max_col",   max_col,   0);
        step();
        chk("t5a_pulse_end", max_valid, 0);
        chk("t5a_hold_data", max_data,  4);
        load_p(2, 3, 3, 1);
        p_valid = 1'b1;
        step();
        p_valid = 1'b0;
        drain4("t5b", 2, 3, 3, 1);
        chk("t5b_max_valid", max_valid, 1);
        chk("t5b_max_data",  max_data,  3);
        chk("t5b_max_row",   max_row,   0);
        chk("t5b_max_col",   max_col,   1);
        step();
        chk("t5b_pulse_end", max_valid, 0);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

`default_nettype wire
